// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/stall control block.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MDWAIT  = 2'd2
  } hz_state_e;

  localparam int REG_AW_DEF = 6;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave is the hazard unit.
interface hazard_stall_unit_if #(
  parameter int REG_AW = hazard_pkg::REG_AW_DEF
);
  logic [REG_AW-1:0] IFID_rs;
  logic [REG_AW-1:0] IFID_rt;
  logic              IFID_use_rs;
  logic              IFID_use_rt;
  logic              IFID_md;
  logic              IDEX_MemRd;
  logic              IDEX_RegWr;
  logic [REG_AW-1:0] IDEX_rdes;
  logic              md_issue;
  logic [REG_AW-1:0] md_rdes;
  logic              md_done;
  logic              branch_taken;
  logic              PCWr;
  logic              IFIDWr;
  logic              IFID_Flush;
  logic              IDEX_Bubble;
  logic              stall;

  modport master (
    output IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt, IFID_md,
           IDEX_MemRd, IDEX_RegWr, IDEX_rdes, md_issue, md_rdes, md_done, branch_taken,
    input  PCWr, IFIDWr, IFID_Flush, IDEX_Bubble, stall
  );

  modport slave (
    input  IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt, IFID_md,
           IDEX_MemRd, IDEX_RegWr, IDEX_rdes, md_issue, md_rdes, md_done, branch_taken,
    output PCWr, IFIDWr, IFID_Flush, IDEX_Bubble, stall
  );
endinterface

// File: rtl/hazard_stall_unit_md_scoreboard.sv
// Single-entry scoreboard tracking the one outstanding mul/div and its destination register.
module md_scoreboard #(
  parameter int REG_AW = hazard_pkg::REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              md_issue,
  input  logic [REG_AW-1:0] md_rdes,
  input  logic              md_done,
  output logic              busy,
  output logic [REG_AW-1:0] busy_rd
);

  // A same-cycle issue overrides the completion; flushes never touch this entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      busy_rd <= '0;
    end else if (md_issue) begin
      busy    <= 1'b1;
      busy_rd <= md_rdes;
    end else if (md_done) begin
      busy    <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush control: load-use, mul/div scoreboard and branch flush.
// Optional stall-cycle counter port stall_cnt exists when HAZARD_PERF_EN is defined.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_stall_unit_if.slave    hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

  hz_state_e         state, state_nxt;
  logic              busy;
  logic [REG_AW-1:0] busy_rd;
  logic              lu_haz, md_haz;
  logic              pc_wr, ifid_wr, flush, bubble, stall;

  md_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .md_issue(hz.md_issue),
    .md_rdes (hz.md_rdes),
    .md_done (hz.md_done),
    .busy    (busy),
    .busy_rd (busy_rd)
  );

  function automatic logic src_match(input logic [REG_AW-1:0] r,
                                     input logic [REG_AW-1:0] rs, input logic use_rs,
                                     input logic [REG_AW-1:0] rt, input logic use_rt);
    return (r != REG_AW'(ZERO_REG)) && ((use_rs && rs == r) || (use_rt && rt == r));
  endfunction

  assign lu_haz = hz.IDEX_MemRd && hz.IDEX_RegWr &&
                  src_match(hz.IDEX_rdes, hz.IFID_rs, hz.IFID_use_rs, hz.IFID_rt, hz.IFID_use_rt);
  assign md_haz = busy && !hz.md_done &&
                  (src_match(busy_rd, hz.IFID_rs, hz.IFID_use_rs, hz.IFID_rt, hz.IFID_use_rt) ||
                   hz.IFID_md);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    pc_wr     = 1'b1;
    ifid_wr   = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    stall     = 1'b0;
    // Flush beats any stall; load-use only counts from RUN since LDSTALL already bubbled once.
    if (hz.branch_taken) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (md_haz) begin
      {pc_wr, ifid_wr, bubble, stall} = 4'b0011;
      state_nxt = MDWAIT;
    end else if (state == RUN && lu_haz) begin
      {pc_wr, ifid_wr, bubble, stall} = 4'b0011;
      state_nxt = LDSTALL;
    end
    if (!rst_n) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      flush   = 1'b1;
      bubble  = 1'b1;
      stall   = 1'b0;
    end
  end

  assign hz.PCWr        = pc_wr;
  assign hz.IFIDWr      = ifid_wr;
  assign hz.IFID_Flush  = flush;
  assign hz.IDEX_Bubble = bubble;
  assign hz.stall       = stall;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, mul/div scoreboard, branch flush, reset.
module tb_hazard_stall_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_stall_unit_if #(.REG_AW(6)) bus ();
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  hazard_stall_unit #(.REG_AW(6), .PERF_CNT_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    bus.IFID_rs = '0; bus.IFID_rt = '0; bus.IFID_use_rs = 0; bus.IFID_use_rt = 0;
    bus.IFID_md = 0; bus.IDEX_MemRd = 0; bus.IDEX_RegWr = 0; bus.IDEX_rdes = '0;
    bus.md_issue = 0; bus.md_rdes = '0; bus.md_done = 0; bus.branch_taken = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clr();
    #3;
    checks++; if (bus.PCWr !== 1'b0) begin errors++; $display("FAIL rst_pcwr got %b want 0", bus.PCWr); end
    checks++; if (bus.IFIDWr !== 1'b0) begin errors++; $display("FAIL rst_ifidwr got %b want 0", bus.IFIDWr); end
    checks++; if (bus.IFID_Flush !== 1'b1) begin errors++; $display("FAIL rst_flush got %b want 1", bus.IFID_Flush); end
    checks++; if (bus.IDEX_Bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble got %b want 1", bus.IDEX_Bubble); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.stall); end
    checks++; if (dut.state !== RUN || dut.u_sb.busy !== 1'b0) begin
      errors++; $display("FAIL rst_state got state=%0d busy=%b want 0/0", dut.state, dut.u_sb.busy); end
`ifdef HAZARD_PERF_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", stall_cnt); end
`endif
    #4 rst_n = 1'b1;
    cyc();
    checks++; if (bus.PCWr !== 1'b1 || bus.IFID_Flush !== 1'b0) begin
      errors++; $display("FAIL run_idle got pcwr=%b flush=%b want 1/0", bus.PCWr, bus.IFID_Flush); end
  endtask

  task automatic test_load_use;
    cyc();
    bus.IDEX_MemRd = 1; bus.IDEX_RegWr = 1; bus.IDEX_rdes = 6'd8; bus.IFID_rs = 6'd8; bus.IFID_use_rs = 1;
    #1;
    checks++; if ({bus.stall, bus.PCWr, bus.IFIDWr, bus.IDEX_Bubble, bus.IFID_Flush} !== 5'b10010) begin
      errors++; $display("FAIL lu_stall got %b want 10010", {bus.stall, bus.PCWr, bus.IFIDWr, bus.IDEX_Bubble, bus.IFID_Flush}); end
    cyc();
    // Inputs left unchanged: the single bubble must be enough.
    checks++; if ({bus.stall, bus.PCWr, bus.IFIDWr, bus.IDEX_Bubble} !== 4'b0110) begin
      errors++; $display("FAIL lu_release got %b want 0110", {bus.stall, bus.PCWr, bus.IFIDWr, bus.IDEX_Bubble}); end
    clr();
  endtask

  task automatic test_load_zero;
    cyc();
    bus.IDEX_MemRd = 1; bus.IDEX_RegWr = 1; bus.IDEX_rdes = 6'd0; bus.IFID_rs = 6'd0; bus.IFID_use_rs = 1;
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.PCWr !== 1'b1) begin
      errors++; $display("FAIL lu_r0 got stall=%b pcwr=%b want 0/1", bus.stall, bus.PCWr); end
    bus.IDEX_rdes = 6'd8; bus.IFID_rs = 6'd8; bus.IFID_use_rs = 0; bus.IFID_rt = 6'd8; bus.IFID_use_rt = 0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_nouse got %b want 0", bus.stall); end
    bus.IDEX_RegWr = 0; bus.IFID_use_rs = 1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_noregwr got %b want 0", bus.stall); end
    bus.IDEX_RegWr = 1; bus.IFID_use_rs = 0; bus.IFID_rs = 6'd1; bus.IFID_use_rt = 1;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.IDEX_Bubble !== 1'b1) begin
      errors++; $display("FAIL lu_rt got stall=%b bubble=%b want 1/1", bus.stall, bus.IDEX_Bubble); end
    clr();
    cyc();
    cyc();
  endtask

  task automatic test_md_dep;
    cyc();
    bus.md_issue = 1; bus.md_rdes = 6'd5; bus.IFID_rt = 6'd5; bus.IFID_use_rt = 1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL md_issue_cycle got %b want 0", bus.stall); end
    cyc();
    bus.md_issue = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.stall !== 1'b1 || bus.PCWr !== 1'b0 || bus.IFIDWr !== 1'b0) begin
        errors++; $display("FAIL md_wait%0d got stall=%b pcwr=%b ifidwr=%b want 1/0/0", i, bus.stall, bus.PCWr, bus.IFIDWr); end
      cyc();
    end
    bus.md_done = 1;
    #1;
    checks++; if ({bus.stall, bus.PCWr, bus.IFIDWr, bus.IDEX_Bubble} !== 4'b0110) begin
      errors++; $display("FAIL md_release got %b want 0110", {bus.stall, bus.PCWr, bus.IFIDWr, bus.IDEX_Bubble}); end
    cyc();
    clr();
    #1;
    checks++; if (dut.u_sb.busy !== 1'b0) begin errors++; $display("FAIL md_busy_clr got %b want 0", dut.u_sb.busy); end
  endtask

  task automatic test_structural;
    cyc();
    bus.md_issue = 1; bus.md_rdes = 6'd3;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL st_issue got %b want 0", bus.stall); end
    cyc();
    bus.md_issue = 0; bus.IFID_md = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL st_stall1 got %b want 1", bus.stall); end
    cyc();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL st_stall2 got %b want 1", bus.stall); end
    cyc();
    bus.md_done = 1;
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.PCWr !== 1'b1) begin
      errors++; $display("FAIL st_release got stall=%b pcwr=%b want 0/1", bus.stall, bus.PCWr); end
    cyc();
    clr();
    // Completion and a new issue on the same edge: entry stays busy with the new rd.
    bus.md_issue = 1; bus.md_rdes = 6'd2;
    cyc();
    bus.md_done = 1; bus.md_rdes = 6'd9;
    cyc();
    clr();
    #1;
    checks++; if (dut.u_sb.busy !== 1'b1 || dut.u_sb.busy_rd !== 6'd9) begin
      errors++; $display("FAIL st_same_cycle got busy=%b rd=%0d want 1/9", dut.u_sb.busy, dut.u_sb.busy_rd); end
    bus.IFID_rs = 6'd9; bus.IFID_use_rs = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL st_new_rd got %b want 1", bus.stall); end
    bus.IFID_rs = 6'd2;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL st_old_rd got %b want 0", bus.stall); end
    bus.IFID_use_rs = 0; bus.md_done = 1;
    cyc();
    clr();
  endtask

  task automatic test_branch_mdwait;
    cyc();
    bus.md_issue = 1; bus.md_rdes = 6'd7;
    cyc();
    bus.md_issue = 0; bus.IFID_rs = 6'd7; bus.IFID_use_rs = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL br_stall1 got %b want 1", bus.stall); end
    cyc();
    bus.branch_taken = 1;
    #1;
    checks++; if (dut.state !== MDWAIT) begin errors++; $display("FAIL br_in_mdwait got %0d want 2", dut.state); end
    checks++; if ({bus.IFID_Flush, bus.IDEX_Bubble, bus.PCWr, bus.stall} !== 4'b1110) begin
      errors++; $display("FAIL br_flush got %b want 1110", {bus.IFID_Flush, bus.IDEX_Bubble, bus.PCWr, bus.stall}); end
    cyc();
    clr();
    #1;
    checks++; if (dut.state !== RUN || dut.u_sb.busy !== 1'b1) begin
      errors++; $display("FAIL br_after got state=%0d busy=%b want 0/1", dut.state, dut.u_sb.busy); end
    bus.IFID_md = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL br_busy_kept got %b want 1", bus.stall); end
    bus.IFID_md = 0; bus.md_done = 1;
    cyc();
    clr();
  endtask

  task automatic test_reset_mid;
    cyc();
    bus.md_issue = 1; bus.md_rdes = 6'd4;
    cyc();
    bus.md_issue = 0; bus.IFID_rt = 6'd4; bus.IFID_use_rt = 1;
    cyc();
    checks++; if (dut.state !== MDWAIT || bus.stall !== 1'b1) begin
      errors++; $display("FAIL rm_pre got state=%0d stall=%b want 2/1", dut.state, bus.stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (dut.state !== RUN || dut.u_sb.busy !== 1'b0) begin
      errors++; $display("FAIL rm_state got state=%0d busy=%b want 0/0", dut.state, dut.u_sb.busy); end
    checks++; if ({bus.PCWr, bus.IFIDWr, bus.IFID_Flush, bus.IDEX_Bubble, bus.stall} !== 5'b00110) begin
      errors++; $display("FAIL rm_outs got %b want 00110", {bus.PCWr, bus.IFIDWr, bus.IFID_Flush, bus.IDEX_Bubble, bus.stall}); end
`ifdef HAZARD_PERF_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_cnt got %0d want 0", stall_cnt); end
`endif
    #2 rst_n = 1'b1;
    cyc();
    checks++; if (bus.stall !== 1'b0 || bus.PCWr !== 1'b1) begin
      errors++; $display("FAIL rm_after got stall=%b pcwr=%b want 0/1", bus.stall, bus.PCWr); end
    clr();
  endtask

  task automatic test_perf;
`ifdef HAZARD_PERF_EN
    cyc();
    bus.md_issue = 1; bus.md_rdes = 6'd6;
    cyc();
    bus.md_issue = 0; bus.IFID_rs = 6'd6; bus.IFID_use_rs = 1;
    repeat (7) cyc();
    bus.md_done = 1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL pf_release got %b want 0", bus.stall); end
    cyc();
    clr();
    checks++; if (stall_cnt !== 32'd7) begin errors++; $display("FAIL pf_cnt got %0d want 7", stall_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_zero();
    test_md_dep();
    test_structural();
    test_branch_mdwait();
    test_reset_mid();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
